dmem_lsu: RTL and testbench

Load/store unit between the RV32IM core's execute stage and the single-port data memory (`data_mem_single`). It accepts one load or store request at a time from the core and drives the RAM port on the memory side. Sub-word stores (SB/SH) are done as read-modify-write, because the RAM has no byte enables. Load results are extracted and sign- or zero-extended before being returned to the core with a one-cycle response pulse.

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/lsu_align.sv | 53 +++++
 rtl/dmem_lsu.sv | 123 ++++++++++++
 tb/tb_dmem_lsu.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store unit.
// funct3 codes, lane widths and the LSU state encoding.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WRITE,
        S_RESP
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// Lane extraction, sign/zero extension, store merge and access check.
// Purely combinational; shared by the load and store paths.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  logic        we,
    output logic [31:0] ld_data,
    output logic [31:0] st_data,
    output logic        err
);

    logic [BYTE_W-1:0] byte_sel;
    logic [HALF_W-1:0] half_sel;

    assign byte_sel = rdata[{off, 3'b000} +: BYTE_W];
    assign half_sel = rdata[{off[1], 4'b0000} +: HALF_W];

    always_comb begin
        ld_data = rdata;
        st_data = rdata;
        err     = 1'b0;
        unique case (funct3)
            F3_B: begin
                ld_data = {{24{byte_sel[BYTE_W-1]}}, byte_sel};
                st_data[{off, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
            end
            F3_H: begin
                ld_data = {{16{half_sel[HALF_W-1]}}, half_sel};
                st_data[{off[1], 4'b0000} +: HALF_W] = wdata[HALF_W-1:0];
                err     = off[0];
            end
            F3_W: begin
                st_data = wdata;
                err     = |off;
            end
            // Unsigned forms exist only for loads.
            F3_BU: begin
                ld_data = {24'd0, byte_sel};
                err     = we;
            end
            F3_HU: begin
                ld_data = {16'd0, half_sel};
                err     = we | off[0];
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the execute stage and the single-port data RAM.
// Sub-word stores are read-modify-write since the RAM has no byte enables.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_w_en,
    output logic [DATA_WIDTH-1:0] mem_w_data,
    input  logic [DATA_WIDTH-1:0] mem_r_data
);

    state_t                state_q;
    state_t                state_d;
    logic [1:0]            off_q;
    logic [2:0]            f3_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  idle;
    logic                  accept;
    logic [1:0]            a_off;
    logic [2:0]            a_f3;
    logic                  a_we;
    logic                  a_err;
    logic [DATA_WIDTH-1:0] ld_data;
    logic [DATA_WIDTH-1:0] st_data;
    logic                  unused_addr_hi;

    assign idle           = (state_q == S_IDLE);
    assign req_ready      = idle;
    assign accept         = req_valid && idle;
    assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH];

    // Checking looks at the incoming request; shaping uses the latched one.
    assign a_off = idle ? req_addr[1:0] : off_q;
    assign a_f3  = idle ? req_funct3    : f3_q;
    assign a_we  = idle ? req_we        : we_q;

    lsu_align u_align (
        .rdata   (mem_r_data),
        .wdata   (wdata_q),
        .off     (a_off),
        .funct3  (a_f3),
        .we      (a_we),
        .ld_data (ld_data),
        .st_data (st_data),
        .err     (a_err)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (a_err)
                        state_d = S_RESP;
                    else if (req_we && req_funct3 == F3_W)
                        state_d = S_WRITE;
                    else
                        state_d = S_RD_ADDR;
                end
            end
            S_RD_ADDR: state_d = S_RD_DATA;
            S_RD_DATA: state_d = we_q ? S_WRITE : S_RESP;
            S_WRITE:   state_d = S_RESP;
            S_RESP:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            off_q      <= '0;
            f3_q       <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            mem_addr   <= '0;
            mem_w_en   <= 1'b0;
            mem_w_data <= '0;
        end else begin
            state_q   <= state_d;
            mem_w_en  <= (state_q == S_WRITE);
            rsp_valid <= (state_q == S_RESP);
            if (accept) begin
                off_q     <= req_addr[1:0];
                f3_q      <= req_funct3;
                we_q      <= req_we;
                wdata_q   <= req_wdata;
                mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                rsp_rdata <= '0;
                rsp_err   <= a_err;
            end
            if (state_q == S_RD_DATA) begin
                if (we_q)
                    mem_w_data <= st_data;
                else
                    rsp_rdata  <= ld_data;
            end
            // Sub-word stores already hold their merged word here.
            if (state_q == S_WRITE && f3_q == F3_W)
                mem_w_data <= wdata_q;
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu with a behavioural RAM and a byte-level
// reference model of memory contents, extension and error rules.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [9:0]  mem_addr;
    logic        mem_w_en;
    logic [31:0] mem_w_data;
    logic [31:0] mem_r_data;

    int total = 0;
    int bad   = 0;
    int n_ops = 0;
    int n_wr  = 0;
    int rsp_cnt  = 0;
    int wr_total = 0;
    bit mon_en   = 0;

    logic [31:0] ram [0:255];
    logic [9:0]  ram_addr_q;
    logic [31:0] gold [0:255];

    always #5 clk = ~clk;

    dmem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_w_en   (mem_w_en),
        .mem_w_data (mem_w_data),
        .mem_r_data (mem_r_data)
    );

    // Single-port RAM: registered address, unregistered read data.
    always @(posedge clk) begin
        if (mem_w_en)
            ram[mem_addr[9:2]] <= mem_w_data;
        ram_addr_q <= mem_addr;
    end
    assign mem_r_data = ram[ram_addr_q[9:2]];

    always @(posedge clk) begin
        if (mon_en && rsp_valid)
            rsp_cnt <= rsp_cnt + 1;
        if (mon_en && mem_w_en)
            wr_total <= wr_total + 1;
    end

    function automatic int widx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    function automatic logic m_err(input logic we, input logic [2:0] f3,
                                   input logic [31:0] a);
        int sz;
        if (we && f3 > 3'd2)
            return 1'b1;
        if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7))
            return 1'b1;
        sz = 1 << f3[1:0];
        return (int'(a[1:0]) % sz) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3,
                                           input logic [31:0] a);
        logic [31:0] w;
        logic [31:0] b;
        logic [31:0] h;
        w = gold[widx(a)] >> (8 * int'(a[1:0]));
        b = w & 32'hFF;
        h = w & 32'hFFFF;
        case (f3)
            3'd0: return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'd1: return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd4: return b;
            3'd5: return h;
            default: return gold[widx(a)];
        endcase
    endfunction

    function automatic void m_store(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] wd);
        logic [31:0] w;
        int o;
        int sz;
        w  = gold[widx(a)];
        o  = int'(a[1:0]);
        sz = 1 << f3[1:0];
        for (int i = 0; i < sz; i++)
            w[8*(o+i) +: 8] = wd[8*i +: 8];
        gold[widx(a)] = w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd);
        logic        e;
        logic [31:0] exp_rd;
        logic [31:0] exp_w;
        int          lat_exp;
        int          lat;
        int          k;
        int          wr_cnt;
        int          wr_k;
        logic [9:0]  wr_a;
        logic [31:0] wr_d;
        bit          got;
        e       = m_err(we, f3, a);
        exp_rd  = (e || we) ? 32'd0 : m_load(f3, a);
        if (we && !e)
            m_store(f3, a, wd);
        exp_w   = gold[widx(a)];
        lat_exp = e ? 1 : (we && f3 == 3'd2) ? 2 : we ? 4 : 3;
        n_ops++;
        if (we && !e)
            n_wr++;

        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        #1;
        check("ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("ready_busy", {31'd0, req_ready}, 32'd0);
        check("mem_addr", {22'd0, mem_addr}, a & 32'h3FC);

        got    = 0;
        k      = 0;
        wr_cnt = 0;
        wr_k   = 0;
        wr_a   = '0;
        wr_d   = '0;
        while (!got && k < 12) begin
            @(posedge clk);
            #1;
            k++;
            if (mem_w_en) begin
                wr_cnt++;
                wr_k = k + 1;
                wr_a = mem_addr;
                wr_d = mem_w_data;
            end
            if (rsp_valid)
                got = 1;
        end
        lat = got ? k : 99;
        rd  = rsp_rdata;
        check("latency", lat, lat_exp);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e});
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("ready_after", {31'd0, req_ready}, 32'd1);
        check("wr_count", wr_cnt, (we && !e) ? 1 : 0);
        if (we && !e) begin
            check("wr_edge", wr_k, lat_exp);
            check("wr_addr", {22'd0, wr_a}, a & 32'h3FC);
            check("wr_data", wr_d, exp_w);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        for (int i = 0; i < 256; i++)
            gold[i] = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        check("rst_mem_w_en", {31'd0, mem_w_en}, 32'd0);
        check("rst_mem_w_data", mem_w_data, 32'd0);
        mon_en = 1;

        for (int i = 0; i < 256; i++)
            do_req(1'b1, 3'd2, i * 4, $urandom, rd);

        do_req(1'b1, 3'd2, 32'h010, 32'hDEADBEEF, rd);
        do_req(1'b0, 3'd2, 32'h010, 32'd0, rd);
        check("lw_010", rd, 32'hDEADBEEF);

        do_req(1'b1, 3'd2, 32'h020, 32'h80FF7F01, rd);
        do_req(1'b0, 3'd0, 32'h021, 32'd0, rd);
        check("lb_021", rd, 32'h0000007F);
        do_req(1'b0, 3'd0, 32'h022, 32'd0, rd);
        check("lb_022", rd, 32'hFFFFFFFF);
        do_req(1'b0, 3'd4, 32'h023, 32'd0, rd);
        check("lbu_023", rd, 32'h00000080);
        do_req(1'b0, 3'd1, 32'h022, 32'd0, rd);
        check("lh_022", rd, 32'hFFFF80FF);
        do_req(1'b0, 3'd5, 32'h022, 32'd0, rd);
        check("lhu_022", rd, 32'h000080FF);

        do_req(1'b1, 3'd2, 32'h030, 32'h11223344, rd);
        do_req(1'b1, 3'd0, 32'h031, 32'h000000AA, rd);
        do_req(1'b0, 3'd2, 32'h030, 32'd0, rd);
        check("sb_merge", rd, 32'h1122AA44);
        do_req(1'b1, 3'd1, 32'h032, 32'h0000BEEF, rd);
        do_req(1'b0, 3'd2, 32'h030, 32'd0, rd);
        check("sh_merge", rd, 32'hBEEFAA44);

        do_req(1'b0, 3'd2, 32'h006, 32'd0, rd);
        do_req(1'b1, 3'd1, 32'h003, 32'h12345678, rd);
        do_req(1'b0, 3'd3, 32'h004, 32'd0, rd);
        do_req(1'b1, 3'd4, 32'h004, 32'h12345678, rd);
        do_req(1'b0, 3'd1, 32'h001, 32'd0, rd);
        do_req(1'b0, 3'd2, 32'h000, 32'd0, rd);

        do_req(1'b1, 3'd2, 32'h00001004, 32'hCAFEF00D, rd);
        do_req(1'b0, 3'd2, 32'h004, 32'd0, rd);
        check("wrap_004", rd, 32'hCAFEF00D);

        // Reset while an SB sits in RD_DATA: dropped, no write, no response.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd0;
        req_addr   = 32'h041;
        req_wdata  = 32'h00000099;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_rd_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rd_rsp", {31'd0, rsp_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("rst_rd_no_wr", {31'd0, mem_w_en}, 32'd0);
            check("rst_rd_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        do_req(1'b0, 3'd2, 32'h040, 32'd0, rd);

        // Reset on the WRITE cycle of an SW must leave RAM untouched.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = 32'h044;
        req_wdata  = 32'h5A5A5A5A;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_wr_ready", {31'd0, req_ready}, 32'd1);
        check("rst_wr_w_en", {31'd0, mem_w_en}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_wr_w_en2", {31'd0, mem_w_en}, 32'd0);
        check("rst_wr_rsp", {31'd0, rsp_valid}, 32'd0);
        do_req(1'b0, 3'd2, 32'h044, 32'd0, rd);

        for (int i = 0; i < 200; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0)
                a = $urandom;
            else
                a = $urandom_range(0, 255);
            do_req(we, f3, a, $urandom, rd);
        end

        repeat (2) @(posedge clk);
        #1;
        check("rsp_count", rsp_cnt, n_ops);
        check("write_count", wr_total, n_wr);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
